// File: rtl/gpio_register_file.sv
// GPIO command decoder and register file.
// Software writes {cmd, enable, data} on the GPO bus and toggles the enable
// bit; each rising enable is decoded once and either updates a configuration
// register, issues a control pulse, or loads a read-back word onto the GPI bus.
module gpio_register_file #(
    parameter int NB_GPIOS        = 32,
    parameter int NB_LOG_ADDR     = 15,
    parameter int NB_LOG_DATA     = 32,
    parameter int NB_BER          = 64,
    parameter int SOFT_RST_CYCLES = 16
) (
    input  logic                   clockdsp,
    input  logic                   in_reset_n,
    input  logic [NB_GPIOS-1:0]    i_gpo,
    output logic [NB_GPIOS-1:0]    o_gpi,
    output logic                   o_soft_reset,
    output logic                   o_enb_tx,
    output logic                   o_enb_rx,
    output logic [1:0]             o_phase,
    output logic                   o_log_run,
    input  logic                   i_log_full,
    output logic [NB_LOG_ADDR-1:0] o_log_addr,
    input  logic [NB_LOG_DATA-1:0] i_log_data,
    input  logic [NB_BER-1:0]      i_ber_errors,
    input  logic [NB_BER-1:0]      i_ber_bits
);

    localparam int CNT_W = $clog2(SOFT_RST_CYCLES + 1);

    localparam logic [7:0] CMD_SOFT_RST = 8'h01;
    localparam logic [7:0] CMD_ENB_TX   = 8'h02;
    localparam logic [7:0] CMD_ENB_RX   = 8'h03;
    localparam logic [7:0] CMD_PHASE    = 8'h04;
    localparam logic [7:0] CMD_LOG_RUN  = 8'h05;
    localparam logic [7:0] CMD_LOG_RD   = 8'h06;
    localparam logic [7:0] CMD_BER_SNAP = 8'h07;
    localparam logic [7:0] CMD_ERR_HI   = 8'h08;
    localparam logic [7:0] CMD_BITS_LO  = 8'h09;
    localparam logic [7:0] CMD_BITS_HI  = 8'h0A;
    localparam logic [7:0] CMD_STATUS   = 8'h0F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_SOFT_RST,
        ST_LOG_RD
    } state_t;

    state_t                 state_reg;
    logic                   en_d_reg;
    logic [7:0]             cmd_reg;
    logic [NB_LOG_ADDR-1:0] data_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [NB_GPIOS-1:0]    gpi_reg;
    logic                   soft_rst_reg;
    logic                   enb_tx_reg;
    logic                   enb_rx_reg;
    logic [1:0]             phase_reg;
    logic                   log_run_reg;
    logic [NB_LOG_ADDR-1:0] log_addr_reg;
    logic [NB_BER-1:0]      errors_snap_reg;
    logic [NB_BER-1:0]      bits_snap_reg;
    logic                   log_done_reg;
    logic                   cmd_err_reg;
    logic                   overrun_reg;

    logic                   start;
    logic [NB_GPIOS-1:0]    status;
    logic                   unused_bits;

    // A command is a rising edge of the enable bit; holding it high is inert.
    assign start = i_gpo[23] & ~en_d_reg;

    assign status = {{(NB_GPIOS-7){1'b0}}, phase_reg, enb_rx_reg, enb_tx_reg,
                     overrun_reg, cmd_err_reg, log_done_reg};

    // Data bits beyond the widest command field and the low half of the
    // error snapshot (returned live by the snapshot command) are never read.
    assign unused_bits = ^{i_gpo[22:NB_LOG_ADDR], errors_snap_reg[31:0]};

    // Command FSM with all registered outputs and status flags.
    always_ff @(posedge clockdsp or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state_reg       <= ST_IDLE;
            en_d_reg        <= 1'b0;
            cmd_reg         <= '0;
            data_reg        <= '0;
            cnt_reg         <= '0;
            gpi_reg         <= '0;
            soft_rst_reg    <= 1'b0;
            enb_tx_reg      <= 1'b0;
            enb_rx_reg      <= 1'b0;
            phase_reg       <= '0;
            log_run_reg     <= 1'b0;
            log_addr_reg    <= '0;
            errors_snap_reg <= '0;
            bits_snap_reg   <= '0;
            log_done_reg    <= 1'b0;
            cmd_err_reg     <= 1'b0;
            overrun_reg     <= 1'b0;
        end else begin
            en_d_reg    <= i_gpo[23];
            log_run_reg <= 1'b0;

            // log_done clears only on the clock that issues the capture pulse.
            if (state_reg == ST_DECODE && cmd_reg == CMD_LOG_RUN)
                log_done_reg <= 1'b0;
            else if (i_log_full)
                log_done_reg <= 1'b1;

            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        cmd_reg   <= i_gpo[31:24];
                        data_reg  <= i_gpo[NB_LOG_ADDR-1:0];
                        state_reg <= ST_DECODE;
                    end
                end

                ST_DECODE: begin
                    state_reg <= ST_IDLE;
                    case (cmd_reg)
                        CMD_SOFT_RST: begin
                            soft_rst_reg <= 1'b1;
                            cnt_reg      <= CNT_W'(SOFT_RST_CYCLES - 1);
                            state_reg    <= ST_SOFT_RST;
                        end
                        CMD_ENB_TX:  enb_tx_reg  <= data_reg[0];
                        CMD_ENB_RX:  enb_rx_reg  <= data_reg[0];
                        CMD_PHASE:   phase_reg   <= data_reg[1:0];
                        CMD_LOG_RUN: log_run_reg <= 1'b1;
                        CMD_LOG_RD: begin
                            log_addr_reg <= data_reg;
                            state_reg    <= ST_LOG_RD;
                        end
                        CMD_BER_SNAP: begin
                            errors_snap_reg <= i_ber_errors;
                            bits_snap_reg   <= i_ber_bits;
                            gpi_reg         <= i_ber_errors[31:0];
                        end
                        CMD_ERR_HI:  gpi_reg <= errors_snap_reg[63:32];
                        CMD_BITS_LO: gpi_reg <= bits_snap_reg[31:0];
                        CMD_BITS_HI: gpi_reg <= bits_snap_reg[63:32];
                        CMD_STATUS: begin
                            // Flags can only be set in other states, so a
                            // simultaneous set never collides with this clear.
                            gpi_reg     <= status;
                            cmd_err_reg <= 1'b0;
                            overrun_reg <= 1'b0;
                        end
                        default: cmd_err_reg <= 1'b1;
                    endcase
                end

                ST_SOFT_RST: begin
                    if (start)
                        overrun_reg <= 1'b1;
                    if (cnt_reg == '0) begin
                        soft_rst_reg <= 1'b0;
                        state_reg    <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end

                ST_LOG_RD: begin
                    if (start)
                        overrun_reg <= 1'b1;
                    gpi_reg   <= i_log_data;
                    state_reg <= ST_IDLE;
                end

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign o_gpi        = gpi_reg;
    assign o_soft_reset = soft_rst_reg;
    assign o_enb_tx     = enb_tx_reg;
    assign o_enb_rx     = enb_rx_reg;
    assign o_phase      = phase_reg;
    assign o_log_run    = log_run_reg;
    assign o_log_addr   = log_addr_reg;

endmodule

// File: tb/tb_gpio_register_file.sv
// Directed testbench for gpio_register_file with a FIFO scoreboard of
// expected values, pushed as stimulus is driven and popped at each check.
module tb_gpio_register_file;

    logic        clockdsp = 1'b0;
    logic        in_reset_n = 1'b0;
    logic [31:0] i_gpo = '0;
    logic [31:0] o_gpi;
    logic        o_soft_reset;
    logic        o_enb_tx;
    logic        o_enb_rx;
    logic [1:0]  o_phase;
    logic        o_log_run;
    logic        i_log_full = 1'b0;
    logic [14:0] o_log_addr;
    logic [31:0] i_log_data;
    logic [63:0] i_ber_errors = '0;
    logic [63:0] i_ber_bits = '0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    gpio_register_file dut (
        .clockdsp     (clockdsp),
        .in_reset_n   (in_reset_n),
        .i_gpo        (i_gpo),
        .o_gpi        (o_gpi),
        .o_soft_reset (o_soft_reset),
        .o_enb_tx     (o_enb_tx),
        .o_enb_rx     (o_enb_rx),
        .o_phase      (o_phase),
        .o_log_run    (o_log_run),
        .i_log_full   (i_log_full),
        .o_log_addr   (o_log_addr),
        .i_log_data   (i_log_data),
        .i_ber_errors (i_ber_errors),
        .i_ber_bits   (i_ber_bits)
    );

    always #5 clockdsp = ~clockdsp;

    // Log memory model: one known word at 0x1234, address-tagged filler elsewhere.
    assign i_log_data = (o_log_addr == 15'h1234) ? 32'hCAFE_BABE : {17'h0, o_log_addr};

    function automatic logic [31:0] stat(input logic done, input logic cerr,
                                         input logic ovr, input logic tx,
                                         input logic rx, input logic [1:0] ph);
        return {25'h0, ph, rx, tx, ovr, cerr, done};
    endfunction

    task automatic tick;
        @(posedge clockdsp);
        @(negedge clockdsp);
    endtask

    task automatic drive(input logic [7:0] cmd, input logic [22:0] data);
        i_gpo = {cmd, 1'b1, data};
    endtask

    // Full command: accept edge, decode edge, then drop enable.
    task automatic send(input logic [7:0] cmd, input logic [22:0] data);
        drive(cmd, data);
        tick;
        tick;
        i_gpo = '0;
        tick;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check_out(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %h required a queued value", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val)
            else begin
                errors++;
                $error("FAIL %s: observed %h required %h", e.tag, obs, e.val);
            end
        end
    endtask

    initial begin
        // Reset state
        tick;
        tick;
        expect_val("reset_ctrl", 32'h0);
        check_out({26'h0, o_soft_reset, o_enb_tx, o_enb_rx, o_phase, o_log_run});
        expect_val("reset_gpi", 32'h0);
        check_out(o_gpi);
        expect_val("reset_log_addr", 32'h0);
        check_out({17'h0, o_log_addr});
        in_reset_n = 1'b1;
        tick;

        // Transmit enable: visible after edge k+1, holding enable is inert
        expect_val("tx_at_k", 32'h0);
        drive(8'h02, 23'h1);
        tick;
        check_out({31'h0, o_enb_tx});
        expect_val("tx_at_k1", 32'h1);
        tick;
        check_out({31'h0, o_enb_tx});
        i_gpo = {8'h02, 1'b1, 23'h0};
        repeat (10) tick;
        expect_val("tx_hold_no_retrigger", 32'h1);
        check_out({31'h0, o_enb_tx});
        i_gpo = '0;
        tick;
        expect_val("rx_set", 32'h1);
        send(8'h03, 23'h1);
        check_out({31'h0, o_enb_rx});

        // BER snapshot and read-back of the frozen copy
        i_ber_errors = 64'h0000_0001_0000_0002;
        i_ber_bits   = 64'hAAAA_BBBB_CCCC_DDDD;
        expect_val("ber_snap_lo", 32'h0000_0002);
        send(8'h07, 23'h0);
        check_out(o_gpi);
        i_ber_errors = 64'h5;
        i_ber_bits   = 64'h1111_2222_3333_4444;
        expect_val("ber_err_hi", 32'h0000_0001);
        send(8'h08, 23'h0);
        check_out(o_gpi);
        expect_val("ber_bits_lo", 32'hCCCC_DDDD);
        send(8'h09, 23'h0);
        check_out(o_gpi);
        expect_val("ber_bits_hi", 32'hAAAA_BBBB);
        send(8'h0A, 23'h0);
        check_out(o_gpi);

        // Log read, upper data bits ignored
        drive(8'h06, 23'h40_1234);
        tick;
        tick;
        expect_val("log_addr", 32'h1234);
        check_out({17'h0, o_log_addr});
        expect_val("log_gpi_pending", 32'hAAAA_BBBB);
        check_out(o_gpi);
        tick;
        expect_val("log_gpi", 32'hCAFE_BABE);
        check_out(o_gpi);
        i_gpo = '0;
        tick;

        // Soft reset pulse with a command dropped mid-pulse
        expect_val("srst_at_k", 32'h0);
        drive(8'h01, 23'h0);
        tick;
        check_out({31'h0, o_soft_reset});
        for (int i = 1; i <= 16; i++) begin
            if (i == 2) i_gpo = '0;
            if (i == 5) drive(8'h04, 23'h3);
            if (i == 7) i_gpo = '0;
            expect_val($sformatf("srst_on_%0d", i), 32'h1);
            tick;
            check_out({31'h0, o_soft_reset});
        end
        expect_val("srst_off", 32'h0);
        tick;
        check_out({31'h0, o_soft_reset});
        expect_val("phase_dropped", 32'h0);
        check_out({30'h0, o_phase});
        expect_val("status_overrun", stat(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0));
        send(8'h0F, 23'h0);
        check_out(o_gpi);
        expect_val("status_overrun_cleared", stat(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0));
        send(8'h0F, 23'h0);
        check_out(o_gpi);

        // Log capture pulse and status flags
        expect_val("log_run_k", 32'h0);
        drive(8'h05, 23'h0);
        tick;
        check_out({31'h0, o_log_run});
        expect_val("log_run_k1", 32'h1);
        tick;
        check_out({31'h0, o_log_run});
        expect_val("log_run_k2", 32'h0);
        tick;
        check_out({31'h0, o_log_run});
        i_gpo = '0;
        tick;
        i_log_full = 1'b1;
        tick;
        expect_val("status_log_done", stat(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0));
        send(8'h0F, 23'h0);
        check_out(o_gpi);
        expect_val("bad_cmd_gpi_kept", stat(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0));
        send(8'h55, 23'h0);
        check_out(o_gpi);
        expect_val("status_cmd_err", stat(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0));
        send(8'h0F, 23'h0);
        check_out(o_gpi);
        expect_val("status_cmd_err_cleared", stat(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0));
        send(8'h0F, 23'h0);
        check_out(o_gpi);
        i_log_full = 1'b0;
        send(8'h05, 23'h0);
        expect_val("status_log_done_cleared", stat(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0));
        send(8'h0F, 23'h0);
        check_out(o_gpi);

        // Asynchronous reset in the middle of a soft-reset pulse
        drive(8'h01, 23'h0);
        tick;
        tick;
        i_gpo = '0;
        tick;
        expect_val("srst_before_async", 32'h1);
        check_out({31'h0, o_soft_reset});
        #1 in_reset_n = 1'b0;
        #1;
        expect_val("async_ctrl", 32'h0);
        check_out({26'h0, o_soft_reset, o_enb_tx, o_enb_rx, o_phase, o_log_run});
        expect_val("async_gpi", 32'h0);
        check_out(o_gpi);
        expect_val("async_log_addr", 32'h0);
        check_out({17'h0, o_log_addr});
        @(negedge clockdsp);
        in_reset_n = 1'b1;
        tick;
        expect_val("srst_after_release", 32'h0);
        check_out({31'h0, o_soft_reset});
        expect_val("idle_after_release", 32'h2);
        send(8'h04, 23'h2);
        check_out({30'h0, o_phase});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
